// File: rtl/jtopl_timer_ctrl.sv
// CPU register front end for the OPL timer pair: decodes the address/data ports, owns
// registers 0x02-0x04, forwards all other writes, and enforces post-write busy time.
module jtopl_timer_ctrl #(
  parameter int unsigned ADDR_WAIT = 12,
  parameter int unsigned DATA_WAIT = 84,
  parameter int unsigned CW        = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  input  logic       flag_A,
  input  logic       flag_B,
  output logic [7:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic       flagen_A,
  output logic       flagen_B,
  output logic       fwd_we,
  output logic [7:0] fwd_sel,
  output logic [7:0] fwd_din
);

  logic          wstb, wstb_q, wr_ev;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    value_a_q, value_a_d, value_b_q, value_b_d;
  logic          load_a_q, load_a_d, load_b_q, load_b_d;
  logic          flagen_a_q, flagen_a_d, flagen_b_q, flagen_b_d;
  logic          clr_q, clr_d;
  logic          fwd_we_q, fwd_we_d;
  logic [7:0]    fwd_sel_q, fwd_sel_d, fwd_din_q, fwd_din_d;
  logic [7:0]    dout_q, dout_d;

  assign wstb  = ~cs_n & ~wr_n;
  assign busy  = (cnt_q != '0);
  // Rising edge of the strobe only; writes landing inside the busy window are ignored.
  assign wr_ev = wstb & ~wstb_q & ~busy;

  always_comb begin
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    value_a_d  = value_a_q;
    value_b_d  = value_b_q;
    load_a_d   = load_a_q;
    load_b_d   = load_b_q;
    flagen_a_d = flagen_a_q;
    flagen_b_d = flagen_b_q;
    clr_d      = 1'b0;
    fwd_we_d   = 1'b0;
    fwd_sel_d  = fwd_sel_q;
    fwd_din_d  = fwd_din_q;
    dout_d     = {flag_A | flag_B, flag_A, flag_B, 5'b0};
    if (wr_ev) begin
      if (!addr) begin
        idx_d = din;
        cnt_d = CW'(ADDR_WAIT);
      end else begin
        cnt_d = CW'(DATA_WAIT);
        case (idx_q)
          8'h02: value_a_d = din;
          8'h03: value_b_d = din;
          8'h04: begin
            if (din[7]) begin
              clr_d = 1'b1;
            end else begin
              flagen_a_d = ~din[6];
              flagen_b_d = ~din[5];
              load_a_d   = din[0];
              load_b_d   = din[1];
            end
          end
          default: begin
            fwd_we_d  = 1'b1;
            fwd_sel_d = idx_q;
            fwd_din_d = din;
          end
        endcase
      end
    end else if (cen && busy) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstb_q     <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= 8'h00;
      value_a_q  <= 8'h00;
      value_b_q  <= 8'h00;
      load_a_q   <= 1'b0;
      load_b_q   <= 1'b0;
      flagen_a_q <= 1'b1;
      flagen_b_q <= 1'b1;
      clr_q      <= 1'b0;
      fwd_we_q   <= 1'b0;
      fwd_sel_q  <= 8'h00;
      fwd_din_q  <= 8'h00;
      dout_q     <= 8'h00;
    end else begin
      wstb_q     <= wstb;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      value_a_q  <= value_a_d;
      value_b_q  <= value_b_d;
      load_a_q   <= load_a_d;
      load_b_q   <= load_b_d;
      flagen_a_q <= flagen_a_d;
      flagen_b_q <= flagen_b_d;
      clr_q      <= clr_d;
      fwd_we_q   <= fwd_we_d;
      fwd_sel_q  <= fwd_sel_d;
      fwd_din_q  <= fwd_din_d;
      dout_q     <= dout_d;
    end
  end

  assign dout       = dout_q;
  assign value_A    = value_a_q;
  assign value_B    = value_b_q;
  assign load_A     = load_a_q;
  assign load_B     = load_b_q;
  assign flagen_A   = flagen_a_q;
  assign flagen_B   = flagen_b_q;
  assign clr_flag_A = clr_q;
  assign clr_flag_B = clr_q;
  assign fwd_we     = fwd_we_q;
  assign fwd_sel    = fwd_sel_q;
  assign fwd_din    = fwd_din_q;

endmodule

// File: tb/tb_jtopl_timer_ctrl.sv
// Bench for jtopl_timer_ctrl: directed scenarios plus random bus traffic, all checked
// cycle by cycle against a transaction-level model of the register map and busy timer.
module tb_jtopl_timer_ctrl;

  localparam int AW = 12;
  localparam int DW = 84;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       addr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       flag_A = 1'b0;
  logic       flag_B = 1'b0;
  logic [7:0] dout, value_A, value_B, fwd_sel, fwd_din;
  logic       busy, load_A, load_B, clr_flag_A, clr_flag_B, flagen_A, flagen_B, fwd_we;

  always #5 clk = ~clk;

  jtopl_timer_ctrl #(.ADDR_WAIT(AW), .DATA_WAIT(DW), .CW(7)) dut (
    .clk(clk), .rst(rst), .cen(cen), .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din),
    .dout(dout), .busy(busy), .flag_A(flag_A), .flag_B(flag_B),
    .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
    .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B), .flagen_A(flagen_A),
    .flagen_B(flagen_B), .fwd_we(fwd_we), .fwd_sel(fwd_sel), .fwd_din(fwd_din)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bus transactions applied to a register map and a wait budget.
  bit         m_prev_stb;
  int         m_left;
  logic [7:0] m_idx, m_va, m_vb, m_fsel, m_fdin, m_dout;
  bit         m_la, m_lb, m_fa, m_fb, m_clr, m_fwd;
  bit         m_stb, m_ev;
  int         busy_ticks, clr_cnt, fwd_cnt;

  always @(posedge clk) begin
    if (cen && busy) busy_ticks++;
    if (clr_flag_A) clr_cnt++;
    if (fwd_we) fwd_cnt++;
    m_stb = !cs_n && !wr_n;
    m_ev  = m_stb && !m_prev_stb && (m_left == 0);
    m_clr = 0;
    m_fwd = 0;
    if (rst) begin
      m_prev_stb = 0; m_left = 0; m_idx = 0; m_va = 0; m_vb = 0;
      m_la = 0; m_lb = 0; m_fa = 1; m_fb = 1; m_fsel = 0; m_fdin = 0; m_dout = 0;
    end else begin
      m_prev_stb = m_stb;
      m_dout = (flag_A ? 8'h40 : 8'h00) + (flag_B ? 8'h20 : 8'h00)
             + ((flag_A || flag_B) ? 8'h80 : 8'h00);
      if (m_ev && !addr) begin
        m_idx  = din;
        m_left = AW;
      end else if (m_ev) begin
        m_left = DW;
        if (m_idx == 8'h02) m_va = din;
        else if (m_idx == 8'h03) m_vb = din;
        else if (m_idx == 8'h04) begin
          if (din >= 8'h80) m_clr = 1;
          else begin
            m_fa = ((din / 64) % 2) == 0;
            m_fb = ((din / 32) % 2) == 0;
            m_la = (din % 2) == 1;
            m_lb = ((din / 2) % 2) == 1;
          end
        end else begin
          m_fwd = 1; m_fsel = m_idx; m_fdin = din;
        end
      end else if (cen && m_left > 0) begin
        m_left = m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_left != 0);
    check("dout", dout, m_dout);
    check("value_A", value_A, m_va);
    check("value_B", value_B, m_vb);
    check("load", {load_A, load_B}, {m_la, m_lb});
    check("flagen", {flagen_A, flagen_B}, {m_fa, m_fb});
    check("clr_flag", {clr_flag_A, clr_flag_B}, {m_clr, m_clr});
    check("fwd_we", fwd_we, m_fwd);
    check("fwd_sel", fwd_sel, m_fsel);
    check("fwd_din", fwd_din, m_fdin);
  end

  bit cen_rand = 0;
  int cen_cnt = 0;
  always @(negedge clk) begin
    cen_cnt++;
    cen = cen_rand ? ($urandom_range(1, 0) == 1) : (cen_cnt % 4 == 0);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic a, input logic [7:0] d, input int hold);
    @(negedge clk);
    cs_n = 0; wr_n = 0; addr = a; din = d;
    repeat (hold) @(negedge clk);
    cs_n = 1; wr_n = 1;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", busy, 0);
  endtask

  initial begin
    cyc(2);
    rst = 0;
    check("rst_value_A", value_A, 8'h00);
    check("rst_flagen_A", flagen_A, 1);
    check("rst_busy", busy, 0);
    check("rst_dout", dout, 8'h00);

    // Timer A value and the DATA_WAIT window
    wr(0, 8'h02, 1);
    wait_idle();
    busy_ticks = 0;
    wr(1, 8'hC0, 1);
    check("value_A_C0", value_A, 8'hC0);
    wait_idle();
    check("data_wait_ticks", busy_ticks, DW);

    busy_ticks = 0;
    wr(0, 8'h04, 1);
    wait_idle();
    check("addr_wait_ticks", busy_ticks, AW);
    wr(1, 8'h01, 1);
    check("load_A_set", load_A, 1);
    wait_idle();
    wr(1, 8'h60, 1);
    check("load_A_clr", load_A, 0);
    check("flagen_AB_masked", {flagen_A, flagen_B}, 2'b00);
    wait_idle();

    // Flag clear pulse
    flag_A = 1;
    cyc(2);
    check("dout_flagA", dout, 8'hC0);
    clr_cnt = 0;
    wr(1, 8'h80, 1);
    cyc(1);
    check("clr_pulses", clr_cnt, 1);
    check("clr_keeps_flagen", {flagen_A, flagen_B}, 2'b00);
    flag_A = 0;
    cyc(2);
    check("dout_cleared", dout, 8'h00);
    wait_idle();

    // Forwarding, drop while busy, long strobe
    wr(0, 8'h20, 1);
    wait_idle();
    fwd_cnt = 0;
    busy_ticks = 0;
    wr(1, 8'h55, 1);
    check("fwd_sel_20", fwd_sel, 8'h20);
    check("fwd_din_55", fwd_din, 8'h55);
    cyc(10);
    wr(1, 8'hAA, 1);
    wait_idle();
    check("fwd_busy_drop", fwd_cnt, 1);
    check("no_restart_ticks", busy_ticks, DW);
    fwd_cnt = 0;
    wr(1, 8'h33, 10);
    wait_idle();
    check("held_strobe_events", fwd_cnt, 1);
    check("held_fwd_din", fwd_din, 8'h33);

    // Reset in the middle of a wait
    wr(1, 8'h11, 1);
    for (int n = 0; n < 1000 && m_left != 40; n++) @(negedge clk);
    check("reached_40", m_left, 40);
    rst = 1;
    cyc(1);
    rst = 0;
    check("rst_mid_busy", busy, 0);
    fwd_cnt = 0;
    wr(1, 8'h77, 1);
    cyc(1);
    check("post_rst_accept", fwd_cnt, 1);
    check("post_rst_sel", fwd_sel, 8'h00);
    wait_idle();

    // Random traffic
    cen_rand = 1;
    for (int i = 0; i < 150; i++) begin
      int r;
      logic [7:0] d;
      r = $urandom_range(9, 0);
      flag_A = ($urandom_range(3, 0) == 0);
      flag_B = ($urandom_range(3, 0) == 0);
      if (r < 4) begin
        d = (r == 0) ? 8'h02 : (r == 1) ? 8'h03 : (r == 2) ? 8'h04 : 8'($urandom);
        wr(0, d, $urandom_range(3, 1));
      end else if (r < 9) begin
        wr(1, 8'($urandom), $urandom_range(3, 1));
      end else begin
        @(negedge clk);
        cs_n = 0;
        @(negedge clk);
        cs_n = 1;
      end
      if ($urandom_range(3, 0) != 0) wait_idle();
      if ($urandom_range(29, 0) == 0) begin
        rst = 1;
        cyc(1);
        rst = 0;
      end
      cyc($urandom_range(3, 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtopl_timer_ctrl.md
Name: jtopl_timer_ctrl

Overview:
CPU-facing register front end that configures and sequences the OPL timer pair. It decodes the two-port OPL bus (address/data) and owns registers 0x02 (timer A value), 0x03 (timer B value) and 0x04 (IRQ reset, masks, start bits). It drives the timer block's value/load/clear/flag-enable inputs, assembles the status byte, and enforces OPL2 post-write busy times. All other register writes are forwarded as one-clock pulses to the FM core.

Parameters:
ADDR_WAIT, 12, busy duration in cen ticks after an address-port write
DATA_WAIT, 84, busy duration in cen ticks after a data-port write
CW, 7, busy counter width; must satisfy 2^CW > max(ADDR_WAIT, DATA_WAIT)

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous reset, active-high
cen  in  1  master clock enable; the busy counter advances only on cen
cs_n  in  1  chip select, active-low
wr_n  in  1  write strobe, active-low
addr  in  1  0 = address port, 1 = data port
din  in  8  CPU write data
dout  out  8  status byte
busy  out  1  high while post-write wait is active
flag_A  in  1  gated flag from the timer block
flag_B  in  1  gated flag from the timer block
value_A  out  8  timer A start value
value_B  out  8  timer B start value
load_A  out  1  timer A run/load level
load_B  out  1  timer B run/load level
clr_flag_A  out  1  one-clk flag clear pulse
clr_flag_B  out  1  one-clk flag clear pulse
flagen_A  out  1  timer A flag enable (not masked)
flagen_B  out  1  timer B flag enable (not masked)
fwd_we  out  1  one-clk write pulse for registers other than 0x02-0x04
fwd_sel  out  8  register index accompanying fwd_we
fwd_din  out  8  data accompanying fwd_we

Behaviour:
- Reset values (rst high on a clk edge): value_A/B=0, load_A/B=0, flagen_A/B=1, clr_flag_A/B=0, fwd_we=0, fwd_sel=0, fwd_din=0, selected index=0, busy=0, busy counter=0, strobe history=inactive.
- Reset mid-busy aborts the wait; busy=0 on the next cycle.
- Write strobe wstb = ~cs_n & ~wr_n, registered each clk.
- Write event = wstb high while the registered copy is low. A strobe held for many cycles yields exactly one event.
- Write events that occur while busy=1 are dropped: no register update, no counter restart.
- addr=0 event: index <= din. Counter loads ADDR_WAIT; busy=1 from the next cycle.
- addr=1 event: acts on the latched index. Counter loads DATA_WAIT.
  - 0x02: value_A <= din.
  - 0x03: value_B <= din.
  - 0x04 with din[7]=1: clr_flag_A and clr_flag_B pulse high for exactly one clk. Masks and start bits are unchanged.
  - 0x04 with din[7]=0: flagen_A <= ~din[6]; flagen_B <= ~din[5]; load_A <= din[0]; load_B <= din[1].
  - Any other index: fwd_we pulses for one clk, with fwd_sel=index and fwd_din=din valid in the same cycle.
- Timing of outputs: register outputs change one clk after the event. Pulses are high only in that cycle.
- Busy counter:
  - Decrements on clk edges with cen=1 while nonzero.
  - busy = (counter != 0).
  - A load value of 0 means no busy.
  - The counter saturates at 0; no wrap.
- Status output, registered each clk: dout = {flag_A|flag_B, flag_A, flag_B, 5'b0}.
  - Updates one clk after a flag changes.
  - Reading has no side effect.
- Rewriting 0x04 with the same start bit does not re-edge load. Restarting a timer requires writing 0, then 1.

Test Plan:
- Reset: assert rst for 2 clk -> value_A=0, load_A=0, flagen_A=1, busy=0, dout=0x00.
- Write addr=0 din=0x02, wait until busy clears, write addr=1 din=0xC0 -> value_A=0xC0 one clk later; busy high for exactly 84 cen ticks (cen every 4 clk -> 336 clk).
- Index 0x04, data 0x01, then data 0x60 -> load_A=1 then load_A=0, flagen_A=0, flagen_B=0; ADDR_WAIT=12 observed after the index write.
- Index 0x04, data 0x80 with flag_A=1 -> clr_flag_A=clr_flag_B=1 for one clk; load/flagen unchanged; dout=0xC0 before the clear, 0x00 after flag_A drops.
- Index 0x20, data 0x55 -> fwd_we single pulse, fwd_sel=0x20, fwd_din=0x55. A second data write during busy -> no pulse, counter not restarted. wr_n held low for 10 clk -> one event only.
- rst asserted mid-busy (counter=40) -> busy=0 next clk; a subsequent write is accepted immediately.
